// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_ld_state_e;

  // Number of bitstream words needed to cover the chain (ceiling division).
  function automatic int ccff_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_bit_serializer.sv
// Word-to-bit serializer toward ccff_head, and bit-to-word deserializer of the
// previous chain contents arriving on ccff_tail.
module ccff_bit_serializer #(
  parameter int WORD_W = 8,
  parameter int WB_W   = $clog2(WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [WB_W-1:0]   word_bits_i,
  input  logic              shift_i,
  input  logic              tail_i,
  output logic              head_o,
  output logic              last_bit_o,
  output logic [WORD_W-1:0] rb_word_o
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] rb_shreg_q, rb_shreg_d;
  logic [WB_W-1:0]   wbit_cnt_q, wbit_cnt_d;
  logic [WB_W-1:0]   word_bits_q, word_bits_d;
  logic [WORD_W:0]   sh_ext;
  logic [WORD_W:0]   rb_ext;
  logic [WORD_W-1:0] rb_next;
  logic [WB_W-1:0]   pad_bits;

  // Widened concatenations keep the shifts legal for WORD_W == 1.
  assign sh_ext  = {shreg_q, 1'b0};
  assign rb_ext  = {rb_shreg_q, tail_i};
  assign rb_next = rb_ext[WORD_W-1:0];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    shreg_d     = shreg_q;
    rb_shreg_d  = rb_shreg_q;
    wbit_cnt_d  = wbit_cnt_q;
    word_bits_d = word_bits_q;
    if (load_i) begin
      shreg_d     = data_i;
      rb_shreg_d  = '0;
      wbit_cnt_d  = '0;
      word_bits_d = word_bits_i;
    end else if (shift_i) begin
      shreg_d    = sh_ext[WORD_W-1:0];
      rb_shreg_d = rb_next;
      wbit_cnt_d = wbit_cnt_q + WB_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      shreg_q     <= '0;
      rb_shreg_q  <= '0;
      wbit_cnt_q  <= '0;
      word_bits_q <= '0;
    end else begin
      shreg_q     <= shreg_d;
      rb_shreg_q  <= rb_shreg_d;
      wbit_cnt_q  <= wbit_cnt_d;
      word_bits_q <= word_bits_d;
    end
  end

  assign head_o     = shreg_q[WORD_W-1];
  assign last_bit_o = shift_i && ((wbit_cnt_q + WB_W'(1)) == word_bits_q);

  // A partial word is left-aligned so its first captured bit lands in the MSB.
  assign pad_bits  = WB_W'(WORD_W) - word_bits_q;
  assign rb_word_o = rb_next << pad_bits;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a configuration flip-flop chain from a word stream, one bit per
// prog_clk, and returns the displaced chain contents as readback words.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              cfg_done,
  output logic              busy
);

  localparam int WB_W = $clog2(WORD_W + 1);

  ccff_ld_state_e    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_inc;
  logic [CNT_W-1:0]  remaining;
  logic [WB_W-1:0]   word_bits;
  logic              m_valid_q, m_valid_d;
  logic [WORD_W-1:0] m_data_q, m_data_d;
  logic              shift_en_q, shift_en_d;
  logic              accept;
  logic              shifting;
  logic              last_bit;
  logic [WORD_W-1:0] rb_word;

  assign shifting    = (state_q == SHIFT);
  assign s_ready     = (state_q == LOAD) && !m_valid_q;
  assign accept      = s_ready && s_valid;
  assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);

  // The last word of the chain may be shorter than WORD_W.
  always_comb begin
    remaining = CNT_W'(CHAIN_LEN) - bit_cnt_q;
    word_bits = WB_W'(WORD_W);
    if (int'(remaining) < WORD_W) begin
      word_bits = WB_W'(remaining);
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_inc;
        if (last_bit) begin
          state_d = (bit_cnt_inc == CNT_W'(CHAIN_LEN)) ? DONE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new readback word can only appear once the previous one has drained,
  // because s_ready is withheld while m_valid is high.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    if (last_bit) begin
      m_valid_d = 1'b1;
      m_data_d  = rb_word;
    end
  end

  assign shift_en_d = (state_d == SHIFT);

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      shift_en_q <= shift_en_d;
    end
  end

  ccff_bit_serializer #(
    .WORD_W (WORD_W),
    .WB_W   (WB_W)
  ) u_ser (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .load_i      (accept),
    .data_i      (s_data),
    .word_bits_i (word_bits),
    .shift_i     (shifting),
    .tail_i      (ccff_tail),
    .head_o      (ccff_head),
    .last_bit_o  (last_bit),
    .rb_word_o   (rb_word)
  );

  assign chain_shift_en = shift_en_q;
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign cfg_done       = (state_q == DONE);
  assign busy           = (state_q == LOAD) || (state_q == SHIFT);

endmodule
